// File: rtl/mips_top.sv
// Single-cycle 32-bit MIPS core: PC, instruction ROM, register file, control,
// ALU and data memory. One instruction retires on every rising clock edge.

module mips_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);
  // Contents are loaded from outside (hierarchically); there is no write port.
  logic [31:0] memory [DEPTH];

  assign instr_o = memory[addr_i];
endmodule

module mips_top #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] alu_out,
  output logic [31:0] reg_write_data
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT
  } alu_op_e;

  logic [31:0] pc_q, pc_d, pc_plus4, instr;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [DMEM_DEPTH];
  logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res, mem_rdata, wb_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_addr;
  logic [15:0] imm;
  logic        reg_write, reg_dst, alu_src, zero_ext, mem_to_reg, mem_write;
  logic        branch, jump;
  alu_op_e     alu_op;
  logic        unused_shamt;

  mips_imem #(.DEPTH(IMEM_DEPTH)) imem (
    .addr_i  (pc_q[IAW+1:2]),
    .instr_o (instr)
  );

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign imm          = instr[15:0];
  assign funct        = instr[5:0];
  assign unused_shamt = ^instr[10:6];

  // Decode; anything not recognised falls through to the all-zero NOP defaults.
  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    zero_ext   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      6'h00: begin
        reg_dst = 1'b1;
        case (funct)
          6'h20: begin alu_op = ALU_ADD; reg_write = 1'b1; end
          6'h22: begin alu_op = ALU_SUB; reg_write = 1'b1; end
          6'h24: begin alu_op = ALU_AND; reg_write = 1'b1; end
          6'h25: begin alu_op = ALU_OR;  reg_write = 1'b1; end
          6'h27: begin alu_op = ALU_NOR; reg_write = 1'b1; end
          6'h2A: begin alu_op = ALU_SLT; reg_write = 1'b1; end
          default: ;
        endcase
      end
      6'h08: begin alu_src = 1'b1; reg_write = 1'b1; end
      6'h0C: begin alu_src = 1'b1; zero_ext = 1'b1; alu_op = ALU_AND; reg_write = 1'b1; end
      6'h0D: begin alu_src = 1'b1; zero_ext = 1'b1; alu_op = ALU_OR;  reg_write = 1'b1; end
      6'h23: begin alu_src = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; end
      6'h2B: begin alu_src = 1'b1; mem_write = 1'b1; end
      6'h04: begin alu_op = ALU_SUB; branch = 1'b1; end
      6'h02: jump = 1'b1;
      default: ;
    endcase
  end

  assign rs_val  = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : regs_q[rt];
  assign imm_ext = zero_ext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  assign alu_b   = alu_src ? imm_ext : rt_val;

  always_comb begin
    alu_res = rs_val + alu_b;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_NOR: alu_res = ~(rs_val | alu_b);
      ALU_SLT: alu_res = ($signed(rs_val) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_res = rs_val + alu_b;
    endcase
  end

  assign mem_rdata = dmem_q[alu_res[DAW+1:2]];
  assign wb_data   = mem_to_reg ? mem_rdata : alu_res;
  assign wr_addr   = reg_dst ? rd : rt;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    pc_d     = pc_plus4;
    if (jump)
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && (rs_val == rt_val))
      pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (reg_write && (wr_addr != 5'd0)) begin
      regs_q[wr_addr] <= wb_data;
    end
  end

  // Data memory keeps its contents across reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (reset && mem_write) dmem_q[alu_res[DAW+1:2]] <= rt_val;
  end

  assign pc_out         = reset ? pc_q    : 32'd0;
  assign alu_out        = reset ? alu_res : 32'd0;
  assign reg_write_data = reset ? wb_data : 32'd0;
endmodule

// File: tb/tb_mips_top.sv
// Bench for mips_top: directed program from the test plan, mid-run reset, then
// random programs compared cycle by cycle against an instruction-level model.

module tb_mips_top;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_out, alu_out, reg_write_data;
  int          checks = 0;
  int          errors = 0;

  mips_top dut (
    .clk            (clk),
    .reset          (reset),
    .pc_out         (pc_out),
    .alu_out        (alu_out),
    .reg_write_data (reg_write_data)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_imem [256];
  logic [31:0] m_dmem [256];
  logic [31:0] e_alu, e_wd, e_npc, e_store;
  logic [4:0]  e_wa;
  logic        e_we, e_mw, e_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_prog(input logic [31:0] prog[$]);
    for (int i = 0; i < 256; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
      dut.imem.memory[i] = m_imem[i];
    end
  endtask

  task automatic model_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  // Evaluate the instruction at m_pc from the ISA rules.
  task automatic model_eval();
    logic [31:0] ins, a, b, simm, zimm;
    ins  = m_imem[m_pc[9:2]];
    a    = m_regs[ins[25:21]];
    b    = m_regs[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    zimm = {16'd0, ins[15:0]};
    e_npc = m_pc + 32'd4;
    e_we = 1'b0; e_mw = 1'b0; e_known = 1'b1;
    e_alu = 32'd0; e_wa = ins[20:16]; e_store = b;
    case (ins[31:26])
      6'h00: begin
        e_wa = ins[15:11];
        e_we = 1'b1;
        case (ins[5:0])
          6'h20: e_alu = a + b;
          6'h22: e_alu = a - b;
          6'h24: e_alu = a & b;
          6'h25: e_alu = a | b;
          6'h27: e_alu = ~(a | b);
          6'h2A: e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e_we = 1'b0; e_known = 1'b0; end
        endcase
      end
      6'h08: begin e_alu = a + simm; e_we = 1'b1; end
      6'h0C: begin e_alu = a & zimm; e_we = 1'b1; end
      6'h0D: begin e_alu = a | zimm; e_we = 1'b1; end
      6'h23: begin e_alu = a + simm; e_we = 1'b1; end
      6'h2B: begin e_alu = a + simm; e_mw = 1'b1; end
      6'h04: begin
        e_alu = a - b;
        if (a == b) e_npc = m_pc + 32'd4 + (simm * 4);
      end
      6'h02: begin
        e_known = 1'b0;
        e_npc = {e_npc[31:28], ins[25:0], 2'b00};
      end
      default: e_known = 1'b0;
    endcase
    e_wd = (ins[31:26] == 6'h23) ? m_dmem[e_alu[9:2]] : e_alu;
  endtask

  task automatic model_commit();
    if (e_we && e_wa != 5'd0) m_regs[e_wa] = e_wd;
    if (e_mw) m_dmem[e_alu[9:2]] = e_store;
    m_pc = e_npc;
  endtask

  // Entered at a falling edge; checks the current instruction, then waits one cycle.
  task automatic run_cycle();
    #1;
    model_eval();
    chk("pc_out", pc_out, m_pc);
    if (e_known) begin
      chk("alu_out", alu_out, e_alu);
      chk("reg_write_data", reg_write_data, e_wd);
    end
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_alu", alu_out, 32'd0);
    chk("rst_wd", reg_write_data, 32'd0);
    model_reset();
    #10;
    chk("rst_pc_held", pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0, 1: begin
        case ($urandom_range(0, 6))
          0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25;
          4: fn = 6'h27; 5: fn = 6'h2A; default: fn = 6'($urandom_range(0, 63));
        endcase
        return {6'h00, rs, rt, rd, 5'd0, fn};
      end
      2: return {6'h08, rs, rt, 16'($urandom)};
      3: return {6'h0C, rs, rt, 16'($urandom)};
      4: return {6'h0D, rs, rt, 16'($urandom)};
      5: return {6'h23, 5'd0, rt, 16'($urandom_range(0, 7) * 4)};
      6: return {6'h2B, 5'd0, rt, 16'($urandom_range(0, 7) * 4)};
      7: return {6'h04, rs, rt, 16'($urandom_range(0, 3))};
      8: return {6'h02, 26'($urandom_range(8, 40))};
      default: return {6'h3F, rs, rt, 16'($urandom)};
    endcase
  endfunction

  initial begin
    logic [31:0] prog[$];
    logic [31:0] exp_pc[12];
    logic [31:0] exp_wd[10];
    exp_pc = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
               32'h18, 32'h1C, 32'h24, 32'h28, 32'h2C, 32'h00};
    exp_wd = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd0, 32'd8, 32'd0, 32'd2, 32'd7};
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;

    prog = '{32'h20010005, 32'h20020003, 32'h00221820, 32'h00222022, 32'h0041302A,
             32'hAC030000, 32'h8C050000, 32'h10210001, 32'h20070063, 32'h10220001,
             32'h20000007, 32'h08000000};
    load_prog(prog);
    @(negedge clk);
    do_reset();

    for (int c = 0; c < 12; c++) begin
      #1;
      chk("dir_pc", pc_out, exp_pc[c]);
      if (c < 10) chk("dir_wd", reg_write_data, exp_wd[c]);
      if (c == 7) chk("beq_alu", alu_out, 32'd0);
      if (c == 8) chk("beq_nt_alu", alu_out, 32'd2);
      run_cycle();
      if (c == 4) begin
        chk("reg3", dut.regs_q[3], 32'd8);
        chk("reg4", dut.regs_q[4], 32'd2);
        chk("reg6", dut.regs_q[6], 32'd1);
      end
      if (c == 5) chk("sw_no_reg5", dut.regs_q[5], 32'd0);
      if (c == 6) chk("lw_reg5", dut.regs_q[5], 32'd8);
      if (c == 10) begin
        chk("reg0", dut.regs_q[0], 32'd0);
        chk("skipped_reg7", dut.regs_q[7], 32'd0);
      end
    end

    for (int c = 0; c < 4; c++) run_cycle();
    // Mid-program reset: state must clear at once, before any clock edge.
    do_reset();
    chk("mid_reg1", dut.regs_q[1], 32'd0);
    chk("mid_reg3", dut.regs_q[3], 32'd0);
    for (int c = 0; c < 3; c++) run_cycle();
    chk("restart_reg1", dut.regs_q[1], 32'd5);

    for (int p = 0; p < 4; p++) begin
      prog = {};
      for (int k = 0; k < 8; k++) prog.push_back({6'h2B, 5'd0, 5'd0, 16'(k * 4)});
      for (int k = 8; k < 48; k++) prog.push_back(rand_instr());
      reset = 1'b0;
      load_prog(prog);
      do_reset();
      for (int c = 0; c < 150; c++) run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
